// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU request framer: delimits frames by t3.5 silence, runs a serial
// CRC-16/MODBUS, filters on slave address and strobes one decoded request.
// Optional feature macro: MODBUS_BCAST_EN (accept address 0x00 as broadcast).
module modbus_rtu_frame_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter logic [7:0]  SADDR      = 8'h01,
  parameter int unsigned T35_CYCLES = 87500
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        frame_bcast,
  output logic [7:0]  func_code,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_data,
  output logic        rx_busy
);

  localparam logic [1:0] S_STARTUP = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RECV    = 2'd2;
  localparam logic [1:0] S_EVAL    = 2'd3;

  // Gap counter spans at least one character time so it never wraps between bytes.
  localparam int unsigned CHAR_CLKS = 11 * (CLK_FREQ / BAUD_RATE);
  localparam int unsigned GAP_SPAN  = (T35_CYCLES > CHAR_CLKS) ? T35_CYCLES : CHAR_CLKS;
  localparam int unsigned GAP_W     = $clog2(GAP_SPAN + 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(T35_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_SAT = '1;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      crc;
  logic [2:0]       crc_bits;
  logic             overrun;
  logic [3:0]       byte_cnt;
  logic [7:0]       frame_buf [0:5];
  logic             gap_end_c;
  logic             addr_hit_c;
  logic             bcast_c;

  // One reflected CRC shift step.
  function automatic logic [15:0] crc_step(input logic [15:0] c);
    crc_step = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

  assign gap_end_c = (gap_cnt == GAP_END);

`ifdef MODBUS_BCAST_EN
  assign bcast_c    = (frame_buf[0] == 8'h00);
  assign addr_hit_c = (frame_buf[0] == SADDR) || bcast_c;
`else
  assign bcast_c    = 1'b0;
  assign addr_hit_c = (frame_buf[0] == SADDR);
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= S_STARTUP;
    else          state <= state_nx;
  end

  // Next-state logic; a byte landing in EVAL means we are mid-frame, so resync.
  always_comb begin
    state_nx = state;
    case (state)
      S_STARTUP: if (!rx_done && gap_end_c) state_nx = S_IDLE;
      S_IDLE:    if (rx_done) state_nx = S_RECV;
      S_RECV:    if (!rx_done && gap_end_c) state_nx = S_EVAL;
      S_EVAL:    state_nx = rx_done ? S_STARTUP : S_IDLE;
      default:   state_nx = S_STARTUP;
    endcase
  end

  // Line-silence counter, cleared by every received byte, saturating.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)             gap_cnt <= '0;
    else if (rx_done)         gap_cnt <= '0;
    else if (gap_cnt != GAP_SAT) gap_cnt <= gap_cnt + GAP_W'(1);
  end

  // Byte capture and serial CRC: first shift happens on the load edge, 8 clocks per byte.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc      <= CRC_INIT;
      crc_bits <= 3'd0;
      overrun  <= 1'b0;
      byte_cnt <= 4'd0;
      for (int i = 0; i < 6; i++) frame_buf[i] <= 8'h00;
    end else begin
      if (crc_bits != 3'd0) begin
        crc      <= crc_step(crc);
        crc_bits <= crc_bits - 3'd1;
      end
      if (rx_done && state == S_IDLE) begin
        crc          <= crc_step(CRC_INIT ^ {8'h00, rx_data});
        crc_bits     <= 3'd7;
        overrun      <= 1'b0;
        byte_cnt     <= 4'd1;
        frame_buf[0] <= rx_data;
      end else if (rx_done && state == S_RECV) begin
        if (crc_bits != 3'd0) begin
          overrun <= 1'b1;
        end else begin
          crc      <= crc_step(crc ^ {8'h00, rx_data});
          crc_bits <= 3'd7;
        end
        if (byte_cnt < 4'd6) frame_buf[byte_cnt[2:0]] <= rx_data;
        if (byte_cnt != 4'hF) byte_cnt <= byte_cnt + 4'd1;
      end
    end
  end

  // Frame evaluation and registered result outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_bcast <= 1'b0;
      func_code   <= 8'h00;
      reg_addr    <= 16'h0000;
      reg_data    <= 16'h0000;
      rx_busy     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      rx_busy     <= (state_nx == S_RECV);
      if (state == S_EVAL && addr_hit_c) begin
        if (overrun) begin
          frame_err <= 1'b1;
          err_code  <= 2'd2;
        end else if (byte_cnt != 4'd8) begin
          frame_err <= 1'b1;
          err_code  <= 2'd1;
        end else if (crc != 16'h0000) begin
          frame_err <= 1'b1;
          err_code  <= 2'd0;
        end else begin
          frame_valid <= 1'b1;
          frame_bcast <= bcast_c;
          func_code   <= frame_buf[1];
          reg_addr    <= {frame_buf[2], frame_buf[3]};
          reg_data    <= {frame_buf[4], frame_buf[5]};
        end
      end
    end
  end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Self-checking bench for modbus_rtu_frame_rx: table of frames plus hand-written
// sequences for overrun, byte-in-EVAL and reset mid-frame.
module tb_modbus_rtu_frame_rx;

  localparam int T35     = 40;
  localparam int SPACING = 12;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        frame_bcast;
  logic [7:0]  func_code;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic        rx_busy;

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  modbus_rtu_frame_rx #(
    .SADDR      (8'h01),
    .T35_CYCLES (T35)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .frame_bcast (frame_bcast),
    .func_code   (func_code),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .rx_busy     (rx_busy)
  );

  typedef logic [0:9][7:0] frame_t;

  typedef struct {
    string       name;
    frame_t      b;
    int          len;
    bit          add_crc;
    bit          exp_v;
    bit          exp_e;
    logic [1:0]  exp_code;
    logic        exp_bc;
    logic [7:0]  exp_func;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input frame_t b, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic frame_t with_crc(input frame_t b, input int n);
    logic [15:0] c;
    frame_t      r;
    r        = b;
    c        = crc16(b, n);
    r[n]     = c[7:0];
    r[n + 1] = c[15:8];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(negedge sys_clk);
    rx_done = 1'b1;
    rx_data = d;
    @(negedge sys_clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input frame_t b, input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i]);
      if (i != n - 1) repeat (spacing - 1) @(negedge sys_clk);
    end
  endtask

  // Observe strobes for a bounded window after the last byte; optionally inject one byte.
  task automatic watch(input int inject_at, output int nv, output int ne, output int lat,
                       output int both, output logic [1:0] code);
    nv = 0; ne = 0; lat = -1; both = 0; code = 2'd0;
    for (int i = 1; i <= T35 + 12; i++) begin
      @(negedge sys_clk);
      rx_done = 1'b0;
      if (frame_valid && frame_err) both++;
      if (frame_valid) nv++;
      if (frame_err) begin
        ne++;
        code = err_code;
      end
      if ((frame_valid || frame_err) && lat < 0) lat = i;
      if (i == inject_at) begin
        rx_done = 1'b1;
        rx_data = 8'h55;
      end
    end
  endtask

  task automatic check_result(input string nm, input bit ev, input bit ee, input logic [1:0] ec,
                              input logic ebc, input logic [7:0] ef, input logic [15:0] ea,
                              input logic [15:0] ed, input int nv, input int ne, input int lat,
                              input int both, input logic [1:0] code);
    chk({nm, ".valid_cnt"}, 64'(nv), 64'(ev));
    chk({nm, ".err_cnt"}, 64'(ne), 64'(ee));
    chk({nm, ".both_high"}, 64'(both), 64'd0);
    if (ee) chk({nm, ".err_code"}, 64'(code), 64'(ec));
    if (ev || ee) chk({nm, ".latency"}, 64'(lat), 64'(T35 + 1));
    chk({nm, ".func"}, 64'(func_code), 64'(ef));
    chk({nm, ".addr"}, 64'(reg_addr), 64'(ea));
    chk({nm, ".data"}, 64'(reg_data), 64'(ed));
    chk({nm, ".bcast"}, 64'(frame_bcast), 64'(ebc));
  endtask

  initial begin
    frame_t      fb;
    frame_t      rd03;
    frame_t      wr06;
    int          n, nv, ne, lat, both;
    logic [1:0]  code;

    rd03 = {8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'hD5, 8'hCA, 8'h00, 8'h00};
    wr06 = with_crc({8'h01, 8'h06, 8'h00, 8'h02, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 6);

    vecs[0] = '{"rd03", rd03, 8, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h03, 16'h0001, 16'h0001};
    vecs[1] = '{"wr06", wr06, 8, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005};
    vecs[2] = '{"crc_bad",
                {8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'hD5, 8'hCB, 8'h00, 8'h00},
                8, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005};
    vecs[3] = '{"short7", rd03, 7, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h06, 16'h0002, 16'h0005};
    vecs[4] = '{"long9", rd03, 9, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h06, 16'h0002, 16'h0005};
    vecs[5] = '{"foreign",
                {8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00},
                6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005};
`ifdef MODBUS_BCAST_EN
    vecs[6] = '{"bcast",
                {8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00},
                6, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'h06, 16'h0001, 16'h0005};
`else
    vecs[6] = '{"bcast",
                {8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00},
                6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005};
`endif
    vecs[7] = '{"rd03_again", rd03, 8, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h03, 16'h0001, 16'h0001};

    reset_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("reset_outs",
        64'({frame_valid, frame_err, err_code, frame_bcast, func_code, reg_addr, reg_data, rx_busy}),
        64'd0);
    reset_n = 1'b1;
    repeat (T35 + 5) @(negedge sys_clk);
    chk("startup_busy", 64'(rx_busy), 64'd0);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      fb = vecs[v].add_crc ? with_crc(vecs[v].b, vecs[v].len) : vecs[v].b;
      n  = vecs[v].add_crc ? vecs[v].len + 2 : vecs[v].len;
      send_frame(fb, n, SPACING);
      watch(-1, nv, ne, lat, both, code);
      check_result(vecs[v].name, vecs[v].exp_v, vecs[v].exp_e, vecs[v].exp_code, vecs[v].exp_bc,
                   vecs[v].exp_func, vecs[v].exp_addr, vecs[v].exp_data, nv, ne, lat, both, code);
    end

    // Overrun: third byte arrives while the CRC engine is still shifting.
    send_byte(rd03[0]);
    chk("ovr.busy_in_recv", 64'(rx_busy), 64'd1);
    repeat (SPACING - 1) @(negedge sys_clk);
    send_byte(rd03[1]);
    repeat (2) @(negedge sys_clk);
    for (int i = 2; i < 8; i++) begin
      send_byte(rd03[i]);
      if (i != 7) repeat (SPACING - 1) @(negedge sys_clk);
    end
    watch(-1, nv, ne, lat, both, code);
    check_result("overrun", 1'b0, 1'b1, 2'd2, 1'b0, 8'h03, 16'h0001, 16'h0001,
                 nv, ne, lat, both, code);
    chk("ovr.busy_after", 64'(rx_busy), 64'd0);

    // Byte landing in EVAL: frame still judged, next frame dropped until silence.
    send_frame(wr06, 8, SPACING);
    watch(T35, nv, ne, lat, both, code);
    check_result("eval_byte", 1'b1, 1'b0, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005,
                 nv, ne, lat, both, code);
    send_frame(rd03, 8, SPACING);
    watch(-1, nv, ne, lat, both, code);
    check_result("resync_drop", 1'b0, 1'b0, 2'd0, 1'b0, 8'h06, 16'h0002, 16'h0005,
                 nv, ne, lat, both, code);
    send_frame(rd03, 8, SPACING);
    watch(-1, nv, ne, lat, both, code);
    check_result("resync_ok", 1'b1, 1'b0, 2'd0, 1'b0, 8'h03, 16'h0001, 16'h0001,
                 nv, ne, lat, both, code);

    // Reset mid-frame: state and outputs cleared, next frame needs startup silence.
    send_frame(wr06, 4, SPACING);
    @(negedge sys_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    send_frame(rd03, 8, SPACING);
    watch(-1, nv, ne, lat, both, code);
    check_result("rst_mid", 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 16'h0000, 16'h0000,
                 nv, ne, lat, both, code);
    send_frame(rd03, 8, SPACING);
    watch(-1, nv, ne, lat, both, code);
    check_result("rst_after", 1'b1, 1'b0, 2'd0, 1'b0, 8'h03, 16'h0001, 16'h0001,
                 nv, ne, lat, both, code);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
